// File: rtl/cbus_sram_responder.sv
// rtl/cbus_sram_responder.sv - cbus memory-side responder backed by a word-addressed SRAM array
package cbus_pkg;
  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN2  = 4'd1;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN8  = 4'd7;
  localparam logic [3:0] MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_sram_responder
  import cbus_pkg::*;
#(
  parameter int MEM_WORDS     = 4096,
  parameter int FIRST_LATENCY = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       busy
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_INIT = 4'((FIRST_LATENCY > 0) ? FIRST_LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} state_t;

  state_t        state;
  logic [AW-1:0] base;
  logic [3:0]    len_q;
  logic [3:0]    beat;
  logic [3:0]    lat;
  logic          wr_q;
  logic          ready_q;
  logic          last_q;
  logic [AW-1:0] idx;
  logic          we;
  logic [31:0]   mem [MEM_WORDS];
  logic          unused_bits;

  // Index wraps naturally at MEM_WORDS through the AW-bit add.
  assign idx = base + AW'(beat);
  assign we  = resetn && ready_q && wr_q;
  assign unused_bits = ^{creq.size, creq.addr[31:AW+2], creq.addr[1:0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      base    <= '0;
      len_q   <= '0;
      beat    <= '0;
      lat     <= '0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (creq.valid) begin
            base  <= creq.addr[AW+1:2];
            len_q <= creq.len;
            wr_q  <= creq.is_write;
            beat  <= '0;
            if (FIRST_LATENCY > 0) begin
              state <= WAIT;
              lat   <= LAT_INIT;
            end else begin
              state   <= BEAT;
              ready_q <= 1'b1;
              last_q  <= (creq.len == 4'd0);
            end
          end
        end
        WAIT: begin
          if (lat == 4'd0) begin
            state   <= BEAT;
            ready_q <= 1'b1;
            last_q  <= (len_q == 4'd0);
          end else begin
            lat <= lat - 4'd1;
          end
        end
        BEAT: begin
          if (beat == len_q) begin
            state   <= DONE;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            beat    <= '0;
          end else begin
            beat   <= beat + 4'd1;
            last_q <= (beat + 4'd1 == len_q);
          end
        end
        // Turnaround: a still-asserted valid is deliberately not sampled here.
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (creq.strobe[b]) mem[idx][8*b +: 8] <= creq.data[8*b +: 8];
      end
    end
  end

  always_comb begin
    cresp       = '0;
    cresp.ready = ready_q;
    cresp.last  = last_q;
    cresp.data  = (ready_q && !wr_q) ? mem[idx] : 32'd0;
  end

  assign busy = (state != IDLE);

`ifndef SYNTHESIS
  property p_valid_held;
    @(posedge clk) disable iff (!resetn) (state == WAIT || state == BEAT) |-> creq.valid;
  endproperty
  a_valid_held: assert property (p_valid_held)
    else $error("cbus initiator dropped valid mid-burst");
`endif
endmodule

// File: tb/tb_cbus_sram_responder.sv
// tb/tb_cbus_sram_responder.sv - randomized self-checking bench for cbus_sram_responder
module tb_cbus_sram_responder;
  import cbus_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cbus_req_t  creq  [2];
  cbus_resp_t cresp [2];
  logic       busy  [2];

  int fl    [2] = '{2, 0};
  int words [2] = '{4096, 16};

  logic [31:0] model [2][4096];
  logic [3:0]  known [2][4096];
  logic [31:0] wd [16];

  int n_checks = 0;
  int n_fail   = 0;

  cbus_sram_responder #(.MEM_WORDS(4096), .FIRST_LATENCY(2)) dut0 (
    .clk(clk), .resetn(resetn), .creq(creq[0]), .cresp(cresp[0]), .busy(busy[0])
  );
  cbus_sram_responder #(.MEM_WORDS(16), .FIRST_LATENCY(0)) dut1 (
    .clk(clk), .resetn(resetn), .creq(creq[1]), .cresp(cresp[1]), .busy(busy[1])
  );

  function automatic int widx(input int d, input logic [31:0] addr, input int beat);
    return (int'(addr >> 2) + beat) & (words[d] - 1);
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  // One transaction, entered and left at the negedge of an idle cycle.
  task automatic do_burst(input int d, input logic wr, input logic [31:0] addr,
                          input logic [3:0] len, input logic [3:0] strobe,
                          input bit hold, input int abort_beat, input string tag);
    int total;
    int beat;
    int i;
    bit er;
    logic [31:0] m;
    total = fl[d] + int'(len) + 1;
    n_checks++;
    if (busy[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_before_accept: got %0b want 0", tag, busy[d]);
    end
    creq[d].valid    = 1'b1;
    creq[d].is_write = wr;
    creq[d].size     = 2'd2;
    creq[d].addr     = addr;
    creq[d].strobe   = strobe;
    creq[d].len      = len;
    creq[d].data     = wd[0];
    @(negedge clk);
    for (int c = 1; c <= total; c++) begin
      er   = (c > fl[d]);
      beat = c - fl[d] - 1;
      n_checks++;
      if (cresp[d].ready !== er) begin
        n_fail++;
        $display("FAIL %s ready cycle %0d: got %0b want %0b", tag, c, cresp[d].ready, er);
      end
      n_checks++;
      if (cresp[d].last !== (er && beat == int'(len))) begin
        n_fail++;
        $display("FAIL %s last cycle %0d: got %0b want %0b", tag, c, cresp[d].last, er && beat == int'(len));
      end
      n_checks++;
      if (busy[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %0b want 1", tag, c, busy[d]);
      end
      if (er) begin
        i = widx(d, addr, beat);
        if (!wr) begin
          m = bmask(known[d][i]);
          if (m != 32'd0) begin
            n_checks++;
            if ((cresp[d].data & m) !== (model[d][i] & m)) begin
              n_fail++;
              $display("FAIL %s rdata beat %0d word %0d: got %08h want %08h", tag, beat, i, cresp[d].data & m, model[d][i] & m);
            end
          end
        end else begin
          n_checks++;
          if (cresp[d].data !== 32'd0) begin
            n_fail++;
            $display("FAIL %s wr_resp_data beat %0d: got %08h want 0", tag, beat, cresp[d].data);
          end
          creq[d].data = wd[beat];
        end
        if (beat == abort_beat) begin
          resetn = 1'b0;
          @(negedge clk);
          n_checks++;
          if ({cresp[d].ready, cresp[d].last, busy[d]} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s after_reset ready/last/busy: got %b want 000", tag, {cresp[d].ready, cresp[d].last, busy[d]});
          end
          resetn = 1'b1;
          creq[d].valid = 1'b0;
          return;
        end
        if (wr) begin
          for (int b = 0; b < 4; b++) begin
            if (strobe[b]) begin
              model[d][i][8*b +: 8] = wd[beat][8*b +: 8];
              known[d][i][b] = 1'b1;
            end
          end
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if ({cresp[d].ready, cresp[d].last, busy[d]} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s done ready/last/busy: got %b want 001", tag, {cresp[d].ready, cresp[d].last, busy[d]});
    end
    if (!hold) creq[d].valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cresp[d].ready, busy[d]} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s idle ready/busy: got %b want 00", tag, {cresp[d].ready, busy[d]});
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({cresp[d].ready, cresp[d].last, cresp[d].data, busy[d]} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got r=%0b l=%0b d=%08h b=%0b want all 0", d, cresp[d].ready, cresp[d].last, cresp[d].data, busy[d]);
      end
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    wd[0] = 32'hDEADBEEF;
    do_burst(0, 1'b1, 32'h100, MLEN1, 4'hF, 1'b0, -1, "single_wr");
    do_burst(0, 1'b0, 32'h100, MLEN1, 4'hF, 1'b0, -1, "single_rd");
  endtask

  task automatic test_burst();
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    do_burst(0, 1'b1, 32'h200, MLEN4, 4'hF, 1'b0, -1, "burst_wr");
    do_burst(0, 1'b0, 32'h200, MLEN4, 4'hF, 1'b0, -1, "burst_rd");
  endtask

  task automatic test_strobe();
    wd[0] = 32'hAABBCCDD;
    do_burst(0, 1'b1, 32'h300, MLEN1, 4'hF, 1'b0, -1, "strobe_pre");
    wd[0] = 32'h11223344;
    do_burst(0, 1'b1, 32'h300, MLEN1, 4'b0101, 1'b0, -1, "strobe_wr");
    do_burst(0, 1'b0, 32'h300, MLEN1, 4'hF, 1'b0, -1, "strobe_rd");
  endtask

  task automatic test_hold_valid();
    do_burst(0, 1'b0, 32'h100, MLEN1, 4'hF, 1'b1, -1, "hold_first");
    do_burst(0, 1'b0, 32'h100, MLEN1, 4'hF, 1'b0, -1, "hold_second");
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 4; k++) wd[k] = 32'(k + 1);
    do_burst(1, 1'b1, 32'h38, MLEN4, 4'hF, 1'b0, -1, "wrap_wr");
    do_burst(1, 1'b0, 32'h38, MLEN4, 4'hF, 1'b0, -1, "wrap_rd");
    do_burst(1, 1'b0, 32'h0, MLEN2, 4'hF, 1'b0, -1, "wrap_rd_low");
  endtask

  task automatic test_reset_mid_burst();
    for (int k = 0; k < 8; k++) wd[k] = $urandom;
    do_burst(0, 1'b1, 32'h500, MLEN8, 4'hF, 1'b0, -1, "rst_pre");
    for (int k = 0; k < 8; k++) wd[k] = $urandom;
    do_burst(0, 1'b1, 32'h500, MLEN8, 4'hF, 1'b0, 2, "rst_wr");
    do_burst(0, 1'b0, 32'h500, MLEN8, 4'hF, 1'b0, -1, "rst_rd");
  endtask

  task automatic test_back_to_back();
    int d;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 1));
      a = (d == 0) ? (32'h1000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3)) : $urandom;
      for (int k = 0; k < 16; k++) wd[k] = $urandom;
      do_burst(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 1'b0, -1, "random");
    end
  endtask

  initial begin
    creq[0] = '0;
    creq[1] = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4096; i++) begin
        model[d][i] = 32'd0;
        known[d][i] = 4'd0;
      end
    test_reset();
    test_single();
    test_burst();
    test_strobe();
    test_hold_valid();
    test_wrap();
    test_reset_mid_burst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cbus_sram_responder.md
Name: cbus_sram_responder

Overview:
- Cache-bus (cbus) responder: the memory-side end of the cbus protocol driven by the D-side load/store buffer and the caches.
- Accepts single and burst read/write requests, holds a word-addressed SRAM array, and returns per-beat ready/last/data.
- Serves as the on-chip backing store for simulation and integration, and as the protocol-checking counterpart to every cbus initiator.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words in the array; must be a power of two.
- FIRST_LATENCY, 2, idle cycles between request acceptance and the first data beat; valid range 0..15.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- creq  in  cbus_req_t  request with fields valid, is_write, size, addr, strobe, data, len.
- cresp  out  cbus_resp_t  response with fields ready, last, data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: cresp.ready=0, cresp.last=0, cresp.data=0, busy=0, state=IDLE, beat counter 0, latency counter 0. Memory contents are not cleared by reset.
- Beats per request = len+1, with MLEN1=0, MLEN2=1, MLEN4=3, MLEN8=7, MLEN16=15 (4-bit field).
- Beat address index = (addr[31:2] + beat) mod MEM_WORDS. It increments linearly with no critical-word wrap. addr[1:0] is ignored for indexing.
- Initiator contract: valid, is_write, addr and len are held stable from assertion until the cycle after last. creq.data may change after each ready beat.
- The responder latches addr, len and is_write at acceptance. Later changes to these fields mid-burst are ignored.
- State IDLE: if creq.valid=1, latch the request. Go to WAIT if FIRST_LATENCY>0, else directly to BEAT in the next cycle.
  - No response is produced in the accept cycle. Minimum first-beat latency is 1 cycle after acceptance.
- State WAIT: count FIRST_LATENCY cycles, then go to BEAT. ready=0 throughout.
- State BEAT: ready=1 every cycle; the beat counter increments each cycle.
  - Read: cresp.data = mem[index] combinationally in the same cycle as ready.
  - Write: on each ready cycle, bytes of mem[index] whose strobe bit is set take the corresponding byte of creq.data. Other bytes are unchanged. cresp.data=0.
  - last=1 together with ready on beat number len. The next state is DONE.
- State DONE: one mandatory turnaround cycle, ready=0, last=0. creq.valid is ignored in this cycle, so a request still held high after last is not restarted. Then go to IDLE.
- Bus occupancy: a new request can be accepted no earlier than 2 cycles after the last beat.
- Throughput: back-to-back bursts cost len+1+FIRST_LATENCY+2 cycles each.
- Outside BEAT, ready, last and data are 0.
- creq.valid dropping mid-burst (protocol violation): the burst still completes with the latched parameters. Writes use whatever creq.data holds. A simulation-only assertion fires.
- Read-after-write: a read accepted after a write's DONE cycle returns the new data. There is no forwarding inside a burst.
- Reset mid-burst: return to IDLE next cycle with outputs at reset values. Write beats already committed remain in memory.
- Address wrap: a burst crossing MEM_WORDS-1 continues at index 0.

Test Plan:
- FIRST_LATENCY=2, single write addr=0x100, strobe=4'b1111, data=0xDEADBEEF, len=MLEN1, then a single read of 0x100 -> write: ready+last at cycle 3 after accept. Read: ready+last with data=0xDEADBEEF at cycle 3, and it is accepted no earlier than 2 cycles after the write's last.
- Burst write MLEN4 to 0x200 with data 0x11,0x22,0x33,0x44 per ready beat, then MLEN4 read -> 4 consecutive ready cycles, last only on the 4th, read data 0x11,0x22,0x33,0x44 in order.
- Pre-load 0xAABBCCDD at 0x300, then single write strobe=4'b0101, data=0x11223344 -> read returns 0xAA22CC44.
- Initiator holds valid high during DONE after a read of 0x100 -> no second ready in DONE; a new transaction starts only from IDLE (ready reappears FIRST_LATENCY+1 cycles after the IDLE cycle).
- MEM_WORDS=16, MLEN4 write at word 14 with data 1,2,3,4 -> words 14,15,0,1 hold 1,2,3,4.
- resetn=0 during beat 2 of an MLEN8 write -> next cycle ready=0, last=0, busy=0; words for beats 0-1 are updated, beats 2-7 are untouched; a new request after reset completes normally.
